// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and a single-port data memory: queues stores in
// program order, drains them when the port is free and forwards data to loads.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      st_valid,
   input  logic [ADDR_W-1:0]         st_addr,
   input  logic [DATA_W-1:0]         st_data,
   input  logic                      ld_valid,
   input  logic [ADDR_W-1:0]         ld_addr,
   output logic                      ld_fwd,
   output logic [DATA_W-1:0]         ld_fwd_data,
   output logic                      stall,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_write_data,
   output logic                      mem_write,
   output logic                      mem_read,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty,
   output logic                      full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] addr_mem_r [DEPTH];
   logic [DATA_W-1:0] data_mem_r [DEPTH];
   logic [DEPTH-1:0]  valid_r;
   logic [PTR_W-1:0]  head_r;
   logic [PTR_W-1:0]  tail_r;
   logic [CNT_W-1:0]  count_r;

   logic              empty_s;
   logic              full_s;
   logic              hit_s;
   logic [DATA_W-1:0] hit_data_s;
   logic [PTR_W-1:0]  scan_idx_s;
   logic              fwd_s;
   logic              load_miss_s;
   logic              drain_s;
   logic              push_s;
   logic              serve_read_s;
   logic              stall_s;

   assign empty_s = (count_r == {CNT_W{1'b0}});
   assign full_s  = (count_r == CNT_DEPTH);

   // Youngest-match search: scan oldest to youngest so the last hit wins.
   always_comb begin
      hit_s      = 1'b0;
      hit_data_s = {DATA_W{1'b0}};
      scan_idx_s = {PTR_W{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx_s = head_r + PTR_W'(k);
         if (valid_r[scan_idx_s] && (addr_mem_r[scan_idx_s] == ld_addr)) begin
            hit_s      = 1'b1;
            hit_data_s = data_mem_r[scan_idx_s];
         end else begin
            hit_s      = hit_s;
            hit_data_s = hit_data_s;
         end
      end
   end

   // Port arbitration: a full buffer always drains; a colliding load is replayed.
   assign fwd_s        = ld_valid & hit_s;
   assign load_miss_s  = ld_valid & ~fwd_s;
   assign drain_s      = ~empty_s & (full_s | ~load_miss_s);
   assign push_s       = st_valid & (~full_s | drain_s);
   assign serve_read_s = load_miss_s & ~drain_s & ~st_valid;
   assign stall_s      = ld_valid & (st_valid | (load_miss_s & full_s));

   // Output drive, forced quiet while reset is held.
   always_comb begin
      ld_fwd         = 1'b0;
      ld_fwd_data    = {DATA_W{1'b0}};
      stall          = 1'b0;
      mem_addr       = {ADDR_W{1'b0}};
      mem_write_data = {DATA_W{1'b0}};
      mem_write      = 1'b0;
      mem_read       = 1'b0;
      count          = {CNT_W{1'b0}};
      empty          = 1'b1;
      full           = 1'b0;
      if (rst) begin
         empty = 1'b1;
      end else begin
         count  = count_r;
         empty  = empty_s;
         full   = full_s;
         stall  = stall_s;
         ld_fwd = fwd_s;
         if (fwd_s) begin
            ld_fwd_data = hit_data_s;
         end else begin
            ld_fwd_data = {DATA_W{1'b0}};
         end
         if (drain_s) begin
            mem_write      = 1'b1;
            mem_addr       = addr_mem_r[head_r];
            mem_write_data = data_mem_r[head_r];
         end else if (serve_read_s) begin
            mem_read = 1'b1;
            mem_addr = ld_addr;
         end else begin
            mem_write = 1'b0;
            mem_read  = 1'b0;
         end
      end
   end

   // Pointer, occupancy and valid-bit state; on a full push+pop the push
   // targets the slot being popped, so its valid set must follow the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
         valid_r <= {DEPTH{1'b0}};
      end else begin
         if (drain_s) begin
            valid_r[head_r] <= 1'b0;
            head_r          <= head_r + PTR_ONE;
         end
         if (push_s) begin
            valid_r[tail_r] <= 1'b1;
            tail_r          <= tail_r + PTR_ONE;
         end
         case ({push_s, drain_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry payload storage; validity is tracked separately so no reset needed.
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         addr_mem_r[tail_r] <= st_addr;
         data_mem_r[tail_r] <= st_data;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, 32-bit address/data).
module tb_store_buffer;

   logic        clk;
   logic        rst;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_fwd;
   logic [31:0] ld_fwd_data;
   logic        stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic        mem_write;
   logic        mem_read;
   logic [2:0]  count;
   logic        empty;
   logic        full;

   int n_checks = 0;
   int n_fail   = 0;

   store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
      .ld_valid(ld_valid), .ld_addr(ld_addr),
      .ld_fwd(ld_fwd), .ld_fwd_data(ld_fwd_data), .stall(stall),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_read(mem_read),
      .count(count), .empty(empty), .full(full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic lv, input logic [31:0] la);
      st_valid = sv;
      st_addr  = sa;
      st_data  = sd;
      ld_valid = lv;
      ld_addr  = la;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 32'h99, 32'h1234, 1'b0, 32'h0);
      // reset held with a store pending
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_mem_write", 64'(mem_write), 64'd0);
      chk("rst_mem_read", 64'(mem_read), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      tick();
      chk("rst2_count", 64'(count), 64'd0);
      tick();
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("post_rst_empty", 64'(empty), 64'd1);
      chk("post_rst_mem_write", 64'(mem_write), 64'd0);

      // single store then drain
      drive(1'b1, 32'h10, 32'hAABBCCDD, 1'b0, 32'h0);
      chk("st1_no_drain", 64'(mem_write), 64'd0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("st1_count", 64'(count), 64'd1);
      chk("st1_mem_write", 64'(mem_write), 64'd1);
      chk("st1_mem_addr", 64'(mem_addr), 64'h10);
      chk("st1_mem_wdata", 64'(mem_write_data), 64'hAABBCCDD);
      tick();
      chk("st1_empty_after", 64'(empty), 64'd1);
      chk("st1_no_more_write", 64'(mem_write), 64'd0);

      // two stores to 0x20 queued behind a colliding load, youngest forwards
      drive(1'b1, 32'h20, 32'h1, 1'b1, 32'h30);
      chk("collide_stall", 64'(stall), 64'd1);
      chk("collide_no_drain", 64'(mem_write), 64'd0);
      tick();
      drive(1'b1, 32'h20, 32'h2, 1'b1, 32'h30);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h30);
      chk("fw_count2", 64'(count), 64'd2);
      chk("miss_mem_read", 64'(mem_read), 64'd1);
      chk("miss_mem_addr", 64'(mem_addr), 64'h30);
      chk("miss_no_fwd", 64'(ld_fwd), 64'd0);
      chk("miss_stall", 64'(stall), 64'd0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
      chk("fw_hit", 64'(ld_fwd), 64'd1);
      chk("fw_youngest", 64'(ld_fwd_data), 64'h2);
      chk("fw_no_read", 64'(mem_read), 64'd0);
      chk("fw_drain", 64'(mem_write), 64'd1);
      chk("fw_drain_data", 64'(mem_write_data), 64'h1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("fw_count1", 64'(count), 64'd1);
      tick();
      chk("fw_empty", 64'(empty), 64'd1);

      // fill to full while loads miss, then a missing load stalls
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(i), 32'h100 + 32'(i), 1'b1, 32'h40);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
      chk("full_count", 64'(count), 64'd4);
      chk("full_flag", 64'(full), 64'd1);
      chk("full_stall", 64'(stall), 64'd1);
      chk("full_drain", 64'(mem_write), 64'd1);
      chk("full_drain_addr", 64'(mem_addr), 64'h0);
      chk("full_no_read", 64'(mem_read), 64'd0);
      tick();
      chk("retry_count", 64'(count), 64'd3);
      chk("retry_read", 64'(mem_read), 64'd1);
      chk("retry_addr", 64'(mem_addr), 64'h40);
      chk("retry_stall", 64'(stall), 64'd0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) tick();
      chk("full_drained", 64'(empty), 64'd1);

      // push and pop together while full
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(i), 32'h200 + 32'(i), 1'b1, 32'h40);
         tick();
      end
      drive(1'b1, 32'h50, 32'h7, 1'b0, 32'h0);
      chk("pp_stall", 64'(stall), 64'd0);
      chk("pp_drain_addr", 64'(mem_addr), 64'h0);
      chk("pp_drain", 64'(mem_write), 64'd1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("pp_count", 64'(count), 64'd4);
      begin
         logic [31:0] exp_a [4];
         logic [31:0] exp_d [4];
         exp_a = '{32'h1, 32'h2, 32'h3, 32'h50};
         exp_d = '{32'h201, 32'h202, 32'h203, 32'h7};
         for (int i = 0; i < 4; i++) begin
            chk("pp_order_we", 64'(mem_write), 64'd1);
            chk("pp_order_addr", 64'(mem_addr), 64'(exp_a[i]));
            chk("pp_order_data", 64'(mem_write_data), 64'(exp_d[i]));
            tick();
         end
      end
      chk("pp_empty", 64'(empty), 64'd1);

      // reset in the middle of operation
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h60 + 32'(i), 32'h300 + 32'(i), 1'b1, 32'h40);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("mid_count3", 64'(count), 64'd3);
      rst = 1'b1;
      #1;
      chk("mid_rst_we", 64'(mem_write), 64'd0);
      chk("mid_rst_empty", 64'(empty), 64'd1);
      tick();
      rst = 1'b0;
      #1;
      chk("mid_count0", 64'(count), 64'd0);
      chk("mid_no_write", 64'(mem_write), 64'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h61);
      chk("mid_ld_fwd", 64'(ld_fwd), 64'd0);
      chk("mid_ld_read", 64'(mem_read), 64'd1);
      chk("mid_ld_addr", 64'(mem_addr), 64'h61);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("idle_stall", 64'(stall), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
